// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch / program-counter block for the 9-bit single-cycle core.
// It addresses the instruction ROM, looks at the returned word to spot the
// halt encoding and the branch offset, and picks the next PC from the
// decoder's branch-enable and the ALU's branch-taken flag.
//
// It also sequences program start and hold, selects one of three entry
// points, and counts executed RUN cycles.
//
// Ports
//   Clk          in   1     system clock, rising edge
//   Reset        in   1     asynchronous, active-low reset
//   Start        in   1     high: hold/arm at entry address; low: run
//   ProgSel      in   2     entry-point select, sampled while armed
//   BranchEn     in   1     current instruction is a conditional branch
//   TakeBranch   in   1     ALU condition result for the current instruction
//   Instruction  in   9     ROM word at ProgCtr (combinational read)
//   ProgCtr      out  PCW   registered program counter / ROM address
//   Done         out  1     registered, high while halted
//   CycleCnt     out  CNTW  saturating count of RUN cycles incl. halt cycle
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned PCW        = 10,
  parameter int unsigned CNTW       = 16,
  parameter int unsigned PROG0_BASE = 0,
  parameter int unsigned PROG1_BASE = 256,
  parameter int unsigned PROG2_BASE = 512,
  parameter logic [8:0]  HALT_WORD  = 9'h1FF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [1:0]      ProgSel,
  input  logic            BranchEn,
  input  logic            TakeBranch,
  input  logic [8:0]      Instruction,
  output logic [PCW-1:0]  ProgCtr,
  output logic            Done,
  output logic [CNTW-1:0] CycleCnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [PCW-1:0] Base0 = PCW'(PROG0_BASE);
  localparam logic [PCW-1:0] Base1 = PCW'(PROG1_BASE);
  localparam logic [PCW-1:0] Base2 = PCW'(PROG2_BASE);

  state_e          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;

  logic [PCW-1:0]  entryPc;
  logic [PCW-1:0]  branchOffset;
  logic [CNTW-1:0] cntNext;
  logic            isHalt;
  logic            isTaken;

  // Entry point for the selected program; select 3 falls back to program 0.
  always_comb begin
    entryPc = Base0;
    case (ProgSel)
      2'd1:    entryPc = Base1;
      2'd2:    entryPc = Base2;
      default: entryPc = Base0;
    endcase
  end

  // The branch displacement lives in the low five bits of the word and is
  // two's complement, so it is sign-extended to PC width. Adding it with
  // plain PCW-bit arithmetic gives the wrap in both directions for free.
  assign branchOffset = {{(PCW-5){Instruction[4]}}, Instruction[4:0]};

  // TakeBranch only matters for instructions the decoder flagged as branches.
  assign isTaken = BranchEn & TakeBranch;
  assign isHalt  = (Instruction == HALT_WORD);

  // The cycle counter sticks at all-ones instead of wrapping, so very long
  // programs read back as "at least this many" rather than a small number.
  assign cntNext = (cnt_q == {CNTW{1'b1}}) ? cnt_q : cnt_q + CNTW'(1);

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Start has priority over everything in RUN so a
  // running program can always be aborted back to the armed state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!Start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (Start) begin
          state_d = S_ARMED;
        end else if (isHalt) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (Start) begin
          state_d = S_ARMED;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-values. The PC is reloaded on every armed cycle so the
  // entry point tracks ProgSel until Start drops; the transition edges into
  // ARMED (abort from RUN, restart from DONE, arm from IDLE) leave PC and
  // counter alone and only the halt flag is cleared.
  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
      end
      S_ARMED: begin
        pc_d   = entryPc;
        cnt_d  = '0;
        done_d = 1'b0;
      end
      S_RUN: begin
        if (Start) begin
          done_d = 1'b0;
        end else if (isHalt) begin
          cnt_d  = cntNext;
          done_d = 1'b1;
        end else if (isTaken) begin
          pc_d  = pc_q + branchOffset;
          cnt_d = cntNext;
        end else begin
          pc_d  = pc_q + PCW'(1);
          cnt_d = cntNext;
        end
      end
      S_DONE: begin
        done_d = ~Start;
      end
      default: begin
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q   <= Base0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign ProgCtr  = pc_q;
  assign Done     = done_q;
  assign CycleCnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. The instruction ROM is an array owned by the bench
// and read combinationally at the DUT's ProgCtr. A behavioural model tracks
// the expected PC, cycle count and Done flag from the program-level rules;
// directed table vectors and hand sequences add fixed expected constants.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int PCW    = 10;
  localparam int CNTW   = 16;
  localparam int PCMOD  = 1024;
  localparam int CNTMAX = 65535;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            Start;
  logic [1:0]      ProgSel;
  logic            BranchEn;
  logic            TakeBranch;
  logic [8:0]      Instruction;
  logic [PCW-1:0]  ProgCtr;
  logic            Done;
  logic [CNTW-1:0] CycleCnt;

  logic [8:0] rom [PCMOD];

  int total = 0;
  int bad   = 0;

  int mState;
  int mPc;
  int mCnt;
  int mDone;

  typedef struct {
    bit       st;
    bit [1:0] sel;
    bit       be;
    bit       tk;
    bit       chkAll;
    int       pc;
    int       done;
    int       cnt;
  } vec_t;

  vec_t vecs[$];

  fetch_unit #(
    .PCW(PCW),
    .CNTW(CNTW),
    .PROG0_BASE(0),
    .PROG1_BASE(256),
    .PROG2_BASE(512),
    .HALT_WORD(9'h1FF)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .ProgSel(ProgSel),
    .BranchEn(BranchEn),
    .TakeBranch(TakeBranch),
    .Instruction(Instruction),
    .ProgCtr(ProgCtr),
    .Done(Done),
    .CycleCnt(CycleCnt)
  );

  assign Instruction = rom[ProgCtr];

  always #5 Clk = ~Clk;

  function automatic int baseOf(int sel);
    case (sel)
      1:       return 256;
      2:       return 512;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mState = M_IDLE;
    mPc    = 0;
    mCnt   = 0;
    mDone  = 0;
  endtask

  // One clock of the program-level behaviour, using the word the ROM holds
  // at the expected PC.
  task automatic modelStep(bit st, int sel, bit be, bit tk);
    int instr;
    int off;
    instr = int'(rom[mPc]);
    off   = instr % 32;
    if (off >= 16) off = off - 32;
    case (mState)
      M_IDLE: begin
        if (st) mState = M_ARMED;
      end
      M_ARMED: begin
        mPc   = baseOf(sel);
        mCnt  = 0;
        mDone = 0;
        if (!st) mState = M_RUN;
      end
      M_RUN: begin
        if (st) begin
          mState = M_ARMED;
        end else if (instr == 511) begin
          mCnt   = (mCnt < CNTMAX) ? mCnt + 1 : CNTMAX;
          mDone  = 1;
          mState = M_DONE;
        end else begin
          if (be && tk) mPc = (mPc + off + PCMOD) % PCMOD;
          else          mPc = (mPc + 1) % PCMOD;
          mCnt = (mCnt < CNTMAX) ? mCnt + 1 : CNTMAX;
        end
      end
      default: begin
        if (st) begin
          mState = M_ARMED;
          mDone  = 0;
        end
      end
    endcase
  endtask

  // Drive one cycle of inputs, advance the model, and compare after the edge.
  task automatic applyStimulus(bit st, int sel, bit be, bit tk);
    Start      = st;
    ProgSel    = 2'(sel);
    BranchEn   = be;
    TakeBranch = tk;
    modelStep(st, sel, be, tk);
    @(posedge Clk);
    #1;
    checkOutput("model_pc", int'(ProgCtr), mPc);
    checkOutput("model_cnt", int'(CycleCnt), mCnt);
    checkOutput("model_done", int'(Done), mDone);
  endtask

  initial begin
    int c0;

    Reset      = 1'b0;
    Start      = 1'b0;
    ProgSel    = 2'd0;
    BranchEn   = 1'b0;
    TakeBranch = 1'b0;
    for (int i = 0; i < PCMOD; i++) rom[i] = 9'h000;
    modelReset();

    #12;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    checkOutput("reset_pc", int'(ProgCtr), 0);
    checkOutput("reset_done", int'(Done), 0);
    checkOutput("reset_cnt", int'(CycleCnt), 0);

    // Run to PC 37, then pull reset between clock edges.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 37; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("run_to_37", int'(ProgCtr), 37);
    #1;
    Reset = 1'b0;
    #1;
    checkOutput("async_reset_pc", int'(ProgCtr), 0);
    checkOutput("async_reset_done", int'(Done), 0);
    checkOutput("async_reset_cnt", int'(CycleCnt), 0);
    modelReset();
    #1;
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("idle_hold_pc", int'(ProgCtr), 0);
    end

    // Program 1 with halt at 260, then restart from DONE with ProgSel=3.
    for (int i = 256; i < 260; i++) rom[i] = 9'(32 * (i - 250));
    rom[260] = 9'h1FF;
    vecs.push_back('{1'b1, 2'd1, 1'b0, 1'b0, 1'b1,   0, 0, 0});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 256, 0, 0});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 256, 0, 0});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 256, 0, 0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 257, 0, 1});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 258, 0, 2});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 259, 0, 3});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 260, 0, 4});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 260, 1, 5});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 260, 1, 5});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 260, 0, 5});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 1'b0, 1'b1,   0, 0, 0});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 1'b0, 1'b1,   0, 0, 0});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].st, int'(vecs[i].sel), vecs[i].be, vecs[i].tk);
      checkOutput("vec_done", int'(Done), vecs[i].done);
      if (vecs[i].chkAll) begin
        checkOutput("vec_pc", int'(ProgCtr), vecs[i].pc);
        checkOutput("vec_cnt", int'(CycleCnt), vecs[i].cnt);
      end
    end
    rom[260] = 9'h000;

    // Branch cases around PC 100.
    for (int i = 0; i < 100; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("reach_100", int'(ProgCtr), 100);
    rom[100] = 9'h0FD;
    applyStimulus(0, 0, 1, 1);
    checkOutput("branch_minus3", int'(ProgCtr), 97);
    rom[97] = 9'h143;
    applyStimulus(0, 0, 1, 1);
    checkOutput("branch_plus3", int'(ProgCtr), 100);
    rom[100] = 9'h0CF;
    applyStimulus(0, 0, 1, 1);
    checkOutput("branch_plus15", int'(ProgCtr), 115);
    rom[115] = 9'h011;
    applyStimulus(0, 0, 1, 1);
    checkOutput("branch_minus15", int'(ProgCtr), 100);
    applyStimulus(0, 0, 1, 0);
    checkOutput("branch_not_taken", int'(ProgCtr), 101);
    rom[101] = 9'h01F;
    applyStimulus(0, 0, 1, 1);
    checkOutput("branch_minus1", int'(ProgCtr), 100);
    applyStimulus(0, 0, 0, 1);
    checkOutput("take_without_en", int'(ProgCtr), 101);

    // Abort back to program 0, then wrap both directions.
    applyStimulus(1, 0, 0, 0);
    checkOutput("abort_pc_hold", int'(ProgCtr), 101);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rearm_pc0", int'(ProgCtr), 0);
    rom[0] = 9'h01F;
    applyStimulus(0, 0, 1, 1);
    checkOutput("wrap_down", int'(ProgCtr), 1023);
    applyStimulus(0, 0, 0, 0);
    checkOutput("wrap_up", int'(ProgCtr), 0);
    rom[0] = 9'h0A0;
    c0 = int'(CycleCnt);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 0, 1, 1);
      checkOutput("self_loop_pc", int'(ProgCtr), 0);
      checkOutput("self_loop_cnt", int'(CycleCnt), c0 + i);
    end

    // Long self-loop drives the counter into saturation.
    for (int i = 0; i < 70000; i++) applyStimulus(0, 0, 1, 1);
    checkOutput("sat_cnt", int'(CycleCnt), 65535);
    checkOutput("sat_pc", int'(ProgCtr), 0);

    // Abort at PC 300 and rearm on program 2.
    rom[0] = 9'h000;
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("prog1_entry", int'(ProgCtr), 256);
    for (int i = 0; i < 44; i++) applyStimulus(0, 1, 0, 0);
    checkOutput("reach_300", int'(ProgCtr), 300);
    applyStimulus(1, 2, 0, 0);
    checkOutput("abort300_hold", int'(ProgCtr), 300);
    applyStimulus(1, 2, 0, 0);
    checkOutput("abort_load_512", int'(ProgCtr), 512);
    checkOutput("abort_cnt_clear", int'(CycleCnt), 0);

    // Random programs against the model.
    for (int i = 0; i < PCMOD; i++) rom[i] = 9'($urandom_range(0, 511));
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 31) == 0), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch / program-counter block for the 9-bit single-cycle core.
- Drives the instruction ROM address and receives the fetched 9-bit word, which it shares with the control decoder.
- Consumes the decoder's branch-enable and the ALU's branch-taken flag to choose the next PC.
- Sequences program start/hold, selects one of three program entry points, detects the halt word, and counts executed cycles.

Parameters:
- PCW, 10, program counter width; PC arithmetic is modulo 2^PCW.
- CNTW, 16, cycle counter width.
- PROG0_BASE, 0, entry address for program 0; also used for ProgSel=3.
- PROG1_BASE, 256, entry address for program 1.
- PROG2_BASE, 512, entry address for program 2.
- HALT_WORD, 9'h1FF, instruction encoding that terminates a program.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  high: hold/arm at entry address; falling edge commences execution.
- ProgSel  input  2  program select, sampled while Start=1.
- BranchEn  input  1  decoder flag: the current instruction is a conditional branch.
- TakeBranch  input  1  ALU condition result for the current instruction.
- Instruction  input  9  current word from the instruction ROM (combinational read of ProgCtr).
- ProgCtr  output  PCW  registered program counter (ROM address).
- Done  output  1  registered; high while halted.
- CycleCnt  output  CNTW  RUN cycles executed, including the halt cycle.

Behaviour:
- Single clock domain. All state is registered.
- Reset low, applied asynchronously at any time including mid-RUN: state=IDLE, ProgCtr=PROG0_BASE, Done=0, CycleCnt=0.
- States are IDLE, ARMED, RUN and DONE.
- IDLE:
  - PC and counters hold.
  - Start=1 -> ARMED.
  - Execution never begins without a Start pulse.
- ARMED:
  - Each cycle: ProgCtr <= base(ProgSel), CycleCnt <= 0, Done <= 0.
  - base: 0 -> PROG0_BASE, 1 -> PROG1_BASE, 2 -> PROG2_BASE, 3 -> PROG0_BASE.
  - Start=0 -> RUN.
  - The first executed instruction is at the base loaded in the last ARMED cycle.
- RUN, evaluated each cycle in priority order:
  1. Start=1: abort. Go to ARMED; the PC load happens in the ARMED cycles.
  2. Instruction==HALT_WORD: PC holds, CycleCnt+1, next state DONE, Done=1 from the next edge.
  3. BranchEn & TakeBranch: ProgCtr <= ProgCtr + sign_extend(Instruction[4:0]).
     - Offset range is -16..+15.
     - Offset 0 is a legal self-loop.
  4. Otherwise: ProgCtr <= ProgCtr + 1.
  - In cases 3 and 4, CycleCnt increments.
  - BranchEn=1 with TakeBranch=0 is treated as plain increment.
  - TakeBranch is ignored when BranchEn=0.
- DONE:
  - ProgCtr, CycleCnt and Done hold; Done=1.
  - Start=1 -> ARMED; Done clears on that edge.
- Arithmetic:
  - PC wraps modulo 2^PCW in both directions: max+1 -> 0, and 0 + (-1) -> 2^PCW-1.
  - CycleCnt saturates at all-ones and does not wrap.
- Latency:
  - The PC update is visible one edge after the instruction is presented.
  - There is no bubble on a taken branch.
- ProgSel changes outside ARMED have no effect.

Test Plan:
1. Reset low mid-RUN with ProgCtr=37 -> ProgCtr=0, Done=0, CycleCnt=0 immediately, asynchronously. Release reset with Start=0 -> ProgCtr stays 0 for 10 cycles (IDLE).
2. Start=1 for 3 cycles with ProgSel=1, then Start=0; ROM holds non-branch words at 256..259 and HALT_WORD at 260:
   - ProgCtr sequence 256, 257, 258, 259, 260, 260.
   - Done=1 one edge after 260 is presented.
   - CycleCnt=5.
3. Branches at PC=100, with BranchEn=1 and TakeBranch=1:
   - Instruction[4:0]=5'b11101 (-3) -> next PC 97.
   - Instruction[4:0]=5'b01111 -> next PC 115.
   - Same 5'b01111 with TakeBranch=0 -> next PC 101.
   - TakeBranch=1 with BranchEn=0 -> 101.
4. Wrap-around:
   - PC=1023 with plain instruction -> 0.
   - PC=0 with taken branch offset -1 -> 1023.
   - Offset 0 taken -> PC holds at 0 for 5 cycles; CycleCnt increments each cycle.
5. Abort and restart:
   - Start=1 at PC=300 during RUN -> ARMED; ProgCtr loads base(ProgSel=2)=512.
   - From DONE, Start=1 with ProgSel=3 -> ProgCtr=0, Done=0, CycleCnt=0.
6. Saturation: run a self-loop for 70000 cycles with CNTW=16 -> CycleCnt holds at 65535; PC unaffected.
